// File: rtl/flash_block_loader_if.sv
// Wishbone pipelined read bus between flash_block_loader (master) and the
// qflexpress flash wrapper (slave). Member names follow the master's view.
interface flash_block_loader_if;
   logic        o_wb_cyc;
   logic        o_wb_stb;
   logic        o_cfg_stb;
   logic        o_wb_we;
   logic [22:0] o_wb_addr;
   logic [31:0] o_wb_data;
   logic        i_wb_stall;
   logic        i_wb_ack;
   logic [31:0] i_wb_data;

   modport master (
      output o_wb_cyc, o_wb_stb, o_cfg_stb, o_wb_we, o_wb_addr, o_wb_data,
      input  i_wb_stall, i_wb_ack, i_wb_data
   );

   modport slave (
      input  o_wb_cyc, o_wb_stb, o_cfg_stb, o_wb_we, o_wb_addr, o_wb_data,
      output i_wb_stall, i_wb_ack, i_wb_data
   );
endinterface

// File: rtl/flash_block_loader.sv
// flash_block_loader: copies a run of 32-bit words from the QSPI flash
// Wishbone slave into a destination memory using pipelined reads with a
// bounded number of outstanding requests, and aborts on a stuck slave.
// Optional feature macro: FLASH_BLOCK_LOADER_BYTESWAP_EN (byte-reverse
// each word before it is written to the destination memory).
module flash_block_loader #(
   parameter int MEM_ADDR_W      = 16,
   parameter int MAX_OUTSTANDING = 4,
   parameter int TIMEOUT_CYCLES  = 1024
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_start,
   input  logic [22:0]           i_flash_addr,
   input  logic [MEM_ADDR_W-1:0] i_mem_addr,
   input  logic [15:0]           i_length,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_error,
   flash_block_loader_if.master  wb,
   output logic                  o_mem_we,
   output logic [MEM_ADDR_W-1:0] o_mem_addr,
   output logic [31:0]           o_mem_data
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_ABORT = 2'd3;

   localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]      OUT_MAX = 4'(MAX_OUTSTANDING);

   logic [1:0]            state_q,       state_d;
   logic [22:0]           flash_addr_q,  flash_addr_d;
   logic [MEM_ADDR_W-1:0] mem_ptr_q,     mem_ptr_d;
   logic [15:0]           remaining_q,   remaining_d;
   logic [3:0]            outstanding_q, outstanding_d;
   logic [TO_W-1:0]       timeout_q,     timeout_d;
   logic                  error_q,       error_d;
   logic                  done_q,        done_d;

   logic                  mem_we_q;
   logic [MEM_ADDR_W-1:0] mem_addr_q;
   logic [31:0]           mem_data_q;

   logic                  cyc;
   logic                  stb;
   logic                  accept;
   logic                  ack_ok;
   logic                  progress;
   logic [31:0]           wr_data;

   // The bus is owned for the whole transfer; requests are throttled by the
   // remaining count and the outstanding window.
   assign cyc      = (state_q == ST_READ) || (state_q == ST_DRAIN);
   assign stb      = (state_q == ST_READ) && (remaining_q != 16'd0) && (outstanding_q < OUT_MAX);
   assign accept   = stb && !wb.i_wb_stall;
   assign ack_ok   = wb.i_wb_ack && cyc;
   assign progress = accept || ack_ok;

`ifdef FLASH_BLOCK_LOADER_BYTESWAP_EN
   assign wr_data = {wb.i_wb_data[7:0], wb.i_wb_data[15:8], wb.i_wb_data[23:16], wb.i_wb_data[31:24]};
`else
   assign wr_data = wb.i_wb_data;
`endif

   // Next-state logic for the transfer sequencer and its counters
   always_comb begin
      // NOTE: every variable is given its hold value first so that no path
      // through the case statement can infer a latch.
      state_d       = state_q;
      flash_addr_d  = flash_addr_q;
      mem_ptr_d     = mem_ptr_q;
      remaining_d   = remaining_q;
      outstanding_d = outstanding_q;
      timeout_d     = timeout_q;
      error_d       = error_q;
      done_d        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               error_d = 1'b0;
               if (i_length != 16'd0) begin
                  flash_addr_d  = i_flash_addr;
                  mem_ptr_d     = i_mem_addr;
                  remaining_d   = i_length;
                  outstanding_d = 4'd0;
                  timeout_d     = '0;
                  state_d       = ST_READ;
               end else begin
                  done_d = 1'b1;
               end
            end
         end

         ST_READ, ST_DRAIN: begin
            if (accept) begin
               flash_addr_d = flash_addr_q + 23'd1;
               remaining_d  = remaining_q - 16'd1;
            end
            if (ack_ok) begin
               mem_ptr_d = mem_ptr_q + MEM_ADDR_W'(1);
            end
            case ({accept, ack_ok})
               2'b10:   outstanding_d = outstanding_q + 4'd1;
               2'b01:   outstanding_d = outstanding_q - 4'd1;
               default: outstanding_d = outstanding_q;
            endcase
            timeout_d = progress ? '0 : timeout_q + TO_W'(1);

            if ((state_q == ST_READ) && accept && (remaining_q == 16'd1)) begin
               state_d = ST_DRAIN;
            end else if ((state_q == ST_DRAIN) && ack_ok && (outstanding_q == 4'd1)) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else if (!progress && (timeout_q == TO_LAST)) begin
               state_d = ST_ABORT;
            end
         end

         default: begin
            // Bus already released; report the failed transfer and go idle.
            state_d       = ST_IDLE;
            error_d       = 1'b1;
            done_d        = 1'b1;
            remaining_d   = 16'd0;
            outstanding_d = 4'd0;
            timeout_d     = '0;
         end
      endcase
   end

   // Sequencer and counter registers
   always_ff @(posedge i_clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (i_reset) begin
         state_q       <= ST_IDLE;
         flash_addr_q  <= '0;
         mem_ptr_q     <= '0;
         remaining_q   <= '0;
         outstanding_q <= '0;
         timeout_q     <= '0;
         error_q       <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         flash_addr_q  <= flash_addr_d;
         mem_ptr_q     <= mem_ptr_d;
         remaining_q   <= remaining_d;
         outstanding_q <= outstanding_d;
         timeout_q     <= timeout_d;
         error_q       <= error_d;
         done_q        <= done_d;
      end
   end

   // Destination write port: one registered write per ack seen while cyc is high
   always_ff @(posedge i_clk) begin
      // NOTE: the address/data registers are reset only because they drive
      // outputs that must read 0 after reset; a pure datapath register would not be.
      if (i_reset) begin
         mem_we_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_data_q <= '0;
      end else begin
         mem_we_q <= ack_ok;
         if (ack_ok) begin
            mem_addr_q <= mem_ptr_q;
            mem_data_q <= wr_data;
         end
      end
   end

   assign o_busy       = (state_q != ST_IDLE);
   assign o_done       = done_q;
   assign o_error      = error_q;
   assign o_mem_we     = mem_we_q;
   assign o_mem_addr   = mem_addr_q;
   assign o_mem_data   = mem_data_q;

   assign wb.o_wb_cyc  = cyc;
   assign wb.o_wb_stb  = stb;
   assign wb.o_cfg_stb = 1'b0;
   assign wb.o_wb_we   = 1'b0;
   assign wb.o_wb_addr = flash_addr_q;
   assign wb.o_wb_data = 32'd0;

endmodule

// File: doc/flash_block_loader.md
# flash_block_loader

Sequencing master for the QSPI flash Wishbone slave (qflexpress behind its wrapper). On a start command it copies a contiguous run of 32-bit words from flash into an on-chip destination memory, such as wavetable or sample RAM, using pipelined Wishbone reads with a bounded number of outstanding requests. It owns the flash bus for the whole transfer, reports busy/done/error to the control logic, and aborts cleanly on a stuck slave.

## Interface
Parameters:
- MEM_ADDR_W, 16, destination memory word-address width
- MAX_OUTSTANDING, 4, max issued-but-unacked reads (1..15)
- TIMEOUT_CYCLES, 1024, idle cycles without bus progress before abort

Ports:
- i_clk  in  1  sole clock
- i_reset  in  1  synchronous, active-high reset
- i_start  in  1  start pulse; sampled only in IDLE
- i_flash_addr  in  23  first flash word address
- i_mem_addr  in  MEM_ADDR_W  first destination word address
- i_length  in  16  word count; 0 is legal
- o_busy  out  1  transfer in progress
- o_done  out  1  one-cycle completion pulse (normal or aborted)
- o_error  out  1  last transfer timed out; held until next accepted start
- o_wb_cyc, o_wb_stb  out  1  Wishbone pipelined master strobes
- o_cfg_stb  out  1  constant 0
- o_wb_we  out  1  constant 0
- o_wb_addr  out  23  read word address
- o_wb_data  out  32  constant 0
- i_wb_stall, i_wb_ack  in  1  slave handshake
- i_wb_data  in  32  read data
- o_mem_we  out  1  destination write strobe
- o_mem_addr  out  MEM_ADDR_W  destination address
- o_mem_data  out  32  destination data

## Operation
- States: IDLE, READ (issuing and collecting), DRAIN (all issued, collecting), ABORT (one cycle).
- IDLE + i_start, length≠0: latch addresses and length, clear o_error, go to READ.
- IDLE + i_start, length=0: no bus activity; o_done pulses the next cycle; o_busy stays 0.
- Request accepted = o_wb_stb && !i_wb_stall. Each acceptance increments o_wb_addr (mod 2^23), decrements requests-remaining, and increments outstanding.
- o_wb_stb is asserted in READ only while requests-remaining>0 and outstanding<MAX_OUTSTANDING. If stalled, stb, addr and the remaining count hold.
- Each i_wb_ack with o_wb_cyc=1 writes i_wb_data (registered) to o_mem_addr, then increments o_mem_addr (mod 2^MEM_ADDR_W) and decrements outstanding.
- Acceptance and ack in the same cycle leave outstanding unchanged.
- Acks while o_wb_cyc=0 are ignored.
- READ→DRAIN when the last request is accepted. DRAIN→IDLE when the final ack arrives.
- i_start while busy is ignored.
- Timeout counter clears on any acceptance or ack. When it reaches TIMEOUT_CYCLES in READ/DRAIN, go to ABORT: drop cyc/stb, set o_error, pulse o_done, return to IDLE. Late acks after that are ignored.

## Timing
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-transfer drops o_wb_cyc at the next edge and discards no further writes.
- i_start at cycle t → o_busy, o_wb_cyc, o_wb_stb high at t+1 with o_wb_addr=i_flash_addr.
- o_wb_cyc stays high continuously from the first stb to the cycle of the last ack.
- Ack at cycle a → o_mem_we=1 at a+1 with matching o_mem_addr/o_mem_data.
- Final ack at cycle f → o_wb_cyc=0 and o_busy=0 at f+1, with o_done=1 at f+1 alongside the last o_mem_we.
- Throughput: 1 word/cycle when the slave neither stalls nor exceeds MAX_OUTSTANDING latency.

## Configuration
- FLASH_BLOCK_LOADER_BYTESWAP_EN defined: o_mem_data = byte-reversed i_wb_data ({[7:0],[15:8],[23:16],[31:24]}), converting flash byte order to little-endian sample words. Latency is unchanged.
- Undefined: o_mem_data = i_wb_data unchanged.

## Test plan
- Basic: flash_addr=0x000100, mem_addr=0x0040, length=8, zero-stall slave with 3-cycle ack latency → 8 writes to 0x0040..0x0047 with data matching the flash model; o_done exactly once; o_busy low afterwards.
- Backpressure: i_wb_stall random 50%, MAX_OUTSTANDING=4, length=100 → outstanding never exceeds 4; addresses strictly sequential with no gaps or duplicates; 100 writes.
- Zero length: length=0 → no o_wb_cyc; o_done one cycle after start; o_busy never high.
- Wrap: flash_addr=0x7FFFFE, mem_addr=0xFFFF, length=4 → flash reads 0x7FFFFE, 0x7FFFFF, 0x000000, 0x000001; mem writes 0xFFFF, 0x0000, 0x0001, 0x0002.
- Timeout: slave stops acking after 2 of 5 words, TIMEOUT_CYCLES=16 → o_wb_cyc drops 16 idle cycles after the last progress; o_error=1; o_done pulse; a late ack produces no write.
- Reset mid-transfer and restart: assert i_reset during word 3 of 10, then restart with length=2 → all outputs 0 after reset; the new transfer completes normally with o_error=0; a start while busy is ignored.
